// File: rtl/apb_master_bridge_if.sv
// Request/response channel plus APB bus bundle for apb_master_bridge.
// Modport master is the bridge view; modport slave is the requester/peripheral view.
interface apb_master_bridge_if #(
  parameter int unsigned APB_ADDR_WIDTH = 12
);
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic [APB_ADDR_WIDTH-1:0] req_addr_i;
  logic [31:0]               req_wdata_i;
  logic                      req_write_i;
  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [31:0]               rsp_rdata_o;
  logic                      rsp_err_o;
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    input  req_valid_i, req_addr_i, req_wdata_i, req_write_i, rsp_ready_i,
    input  PRDATA, PREADY, PSLVERR,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );

  modport slave (
    output req_valid_i, req_addr_i, req_wdata_i, req_write_i, rsp_ready_i,
    output PRDATA, PREADY, PSLVERR,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding valid/ready to APB initiator; all outputs registered.
// Optional ACCESS wait-state timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic            HCLK,
  input logic            HRESETn,
  apb_master_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES out of range 1..65535");
  end

  state_e                    state_q;
  logic                      req_ready_q;
  logic                      rsp_valid_q;
  logic                      rsp_err_q;
  logic [31:0]               rsp_rdata_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [31:0]               pwdata_q;
  logic                      pwrite_q;
  logic                      psel_q;
  logic                      penable_q;
`ifdef APB_MASTER_TIMEOUT_EN
  logic [15:0]               wait_cnt_q;
`endif

  // SETUP launches the APB setup phase; ACCESS first raises PENABLE, then waits on PREADY.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid_i && req_ready_q) begin
            paddr_q     <= bus.req_addr_i & ~APB_ADDR_WIDTH'(3);
            pwdata_q    <= bus.req_wdata_i;
            pwrite_q    <= bus.req_write_i;
            req_ready_q <= 1'b0;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          psel_q     <= 1'b1;
          state_q    <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        ACCESS: begin
          if (!penable_q) begin
            penable_q <= 1'b1;
          end else if (bus.PREADY) begin
            rsp_rdata_q <= (!pwrite_q && !bus.PSLVERR) ? bus.PRDATA : 32'h0;
            rsp_err_q   <= bus.PSLVERR;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          // Limit reached in this wait cycle: abort with error, PREADY=1 above wins.
          else if (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            wait_cnt_q  <= '0;
            state_q     <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
`endif
        end
        RESP: begin
          if (rsp_valid_q && bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o = req_ready_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge; covers the timeout path
// too when built with APB_MASTER_TIMEOUT_EN.
module tb_apb_master_bridge;
  localparam int unsigned AW = 12;
  localparam int unsigned TO = 4;

  logic HCLK;
  logic HRESETn;
  int   tests;
  int   fails;

  apb_master_bridge_if #(.APB_ADDR_WIDTH(AW)) bus ();

  apb_master_bridge #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.master)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [AW-1:0] addr, input logic [31:0] wdata, input logic wr);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    bus.req_write_i = wr;
    step();
    bus.req_valid_i = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    HRESETn         = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.req_write_i = 1'b0;
    bus.rsp_ready_i = 1'b0;
    bus.PRDATA      = '0;
    bus.PREADY      = 1'b1;
    bus.PSLVERR     = 1'b0;

    // Reset values
    step(); step();
    chk("rst_psel",    32'(bus.PSEL), 32'h0);
    chk("rst_penable", 32'(bus.PENABLE), 32'h0);
    chk("rst_pwrite",  32'(bus.PWRITE), 32'h0);
    chk("rst_paddr",   32'(bus.PADDR), 32'h0);
    chk("rst_pwdata",  bus.PWDATA, 32'h0);
    chk("rst_rspv",    32'(bus.rsp_valid_o), 32'h0);
    chk("rst_rsperr",  32'(bus.rsp_err_o), 32'h0);
    chk("rst_rdata",   bus.rsp_rdata_o, 32'h0);
    HRESETn = 1'b1;
    step();
    chk("rst_ready",   32'(bus.req_ready_o), 32'h1);

    // Zero-wait write to 0x014
    issue(12'h014, 32'hDEADBEEF, 1'b1);
    chk("wr_n_psel",   32'(bus.PSEL), 32'h0);
    chk("wr_n_ready",  32'(bus.req_ready_o), 32'h0);
    step();
    chk("wr_setup_psel", 32'(bus.PSEL), 32'h1);
    chk("wr_setup_pen",  32'(bus.PENABLE), 32'h0);
    chk("wr_paddr",      32'(bus.PADDR), 32'h014);
    chk("wr_pwrite",     32'(bus.PWRITE), 32'h1);
    chk("wr_pwdata",     bus.PWDATA, 32'hDEADBEEF);
    step();
    chk("wr_acc_pen",    32'(bus.PENABLE), 32'h1);
    chk("wr_acc_rspv",   32'(bus.rsp_valid_o), 32'h0);
    step();
    chk("wr_rspv",       32'(bus.rsp_valid_o), 32'h1);
    chk("wr_rsperr",     32'(bus.rsp_err_o), 32'h0);
    chk("wr_rdata",      bus.rsp_rdata_o, 32'h0);
    chk("wr_psel_off",   32'(bus.PSEL), 32'h0);
    bus.rsp_ready_i = 1'b1;
    step();
    chk("wr_done_rspv",  32'(bus.rsp_valid_o), 32'h0);
    chk("wr_done_ready", 32'(bus.req_ready_o), 32'h1);
    bus.rsp_ready_i = 1'b0;

    // Read 0x007 with 3 wait states, then held response
    bus.PREADY = 1'b0;
    issue(12'h007, 32'h0, 1'b0);
    step();
    chk("rd_paddr_setup", 32'(bus.PADDR), 32'h004);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("rd_wait_pen",  32'(bus.PENABLE), 32'h1);
      chk("rd_wait_addr", 32'(bus.PADDR), 32'h004);
      chk("rd_wait_rspv", 32'(bus.rsp_valid_o), 32'h0);
      step();
    end
    chk("rd_acc4_pen", 32'(bus.PENABLE), 32'h1);
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h12345678;
    step();
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'hCAFEF00D;
    chk("rd_rspv",  32'(bus.rsp_valid_o), 32'h1);
    chk("rd_rdata", bus.rsp_rdata_o, 32'h12345678);
    chk("rd_err",   32'(bus.rsp_err_o), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_rspv",  32'(bus.rsp_valid_o), 32'h1);
      chk("hold_rdata", bus.rsp_rdata_o, 32'h12345678);
      chk("hold_err",   32'(bus.rsp_err_o), 32'h0);
      chk("hold_ready", 32'(bus.req_ready_o), 32'h0);
      chk("hold_psel",  32'(bus.PSEL), 32'h0);
    end
    bus.rsp_ready_i = 1'b1;
    step();
    chk("hold_done_rspv",  32'(bus.rsp_valid_o), 32'h0);
    chk("hold_done_ready", 32'(bus.req_ready_o), 32'h1);

    // Read with slave error
    bus.PREADY  = 1'b1;
    bus.PSLVERR = 1'b1;
    bus.PRDATA  = 32'hFFFFFFFF;
    bus.rsp_ready_i = 1'b0;
    issue(12'h100, 32'h0, 1'b0);
    step(); step(); step();
    chk("err_rspv",  32'(bus.rsp_valid_o), 32'h1);
    chk("err_err",   32'(bus.rsp_err_o), 32'h1);
    chk("err_rdata", bus.rsp_rdata_o, 32'h0);
    bus.PSLVERR = 1'b0;
    bus.rsp_ready_i = 1'b1;
    step();
    chk("err_done_ready", 32'(bus.req_ready_o), 32'h1);

    // Reset in the middle of ACCESS
    bus.PREADY = 1'b0;
    issue(12'h020, 32'h0, 1'b0);
    step(); step(); step();
    chk("mrst_pen_pre", 32'(bus.PENABLE), 32'h1);
    HRESETn = 1'b0;
    step();
    chk("mrst_psel",  32'(bus.PSEL), 32'h0);
    chk("mrst_pen",   32'(bus.PENABLE), 32'h0);
    chk("mrst_rspv",  32'(bus.rsp_valid_o), 32'h0);
    chk("mrst_paddr", 32'(bus.PADDR), 32'h0);
    HRESETn = 1'b1;
    bus.PREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mrst_ready", 32'(bus.req_ready_o), 32'h1);
      chk("mrst_norsp", 32'(bus.rsp_valid_o), 32'h0);
      chk("mrst_idle",  32'(bus.PSEL), 32'h0);
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // Timeout after TO wait cycles
    bus.PREADY = 1'b0;
    bus.rsp_ready_i = 1'b0;
    issue(12'h040, 32'h0, 1'b0);
    step(); step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_wait_psel", 32'(bus.PSEL), 32'h1);
    end
    step();
    chk("to_psel",  32'(bus.PSEL), 32'h0);
    chk("to_rspv",  32'(bus.rsp_valid_o), 32'h1);
    chk("to_err",   32'(bus.rsp_err_o), 32'h1);
    chk("to_rdata", bus.rsp_rdata_o, 32'h0);
    bus.rsp_ready_i = 1'b1;
    step();
    bus.rsp_ready_i = 1'b0;

    // PREADY in the limit cycle completes normally
    issue(12'h044, 32'h0, 1'b0);
    step(); step();
    step(); step(); step();
    chk("to_late_psel", 32'(bus.PSEL), 32'h1);
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'hA5A55A5A;
    step();
    chk("to_late_rspv",  32'(bus.rsp_valid_o), 32'h1);
    chk("to_late_err",   32'(bus.rsp_err_o), 32'h0);
    chk("to_late_rdata", bus.rsp_rdata_o, 32'hA5A55A5A);
    bus.rsp_ready_i = 1'b1;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
